// File: rtl/ext_pkg.sv
// Shared types for the registered operand extender: operation codes, occupancy
// states and the byte-offset width helper.
package ext_pkg;

  typedef enum logic [2:0] {
    EXT_SEXT = 3'd0,
    EXT_ZEXT = 3'd1,
    EXT_LUI  = 3'd2,
    EXT_LB   = 3'd3,
    EXT_LBU  = 3'd4,
    EXT_LH   = 3'd5,
    EXT_LHU  = 3'd6,
    EXT_PASS = 3'd7
  } ext_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ext_state_e;

  // Bits needed to name one byte lane of a data_w-bit word.
  function automatic int unsigned off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Valid/ready handshake bundle between the ID/MEM datapath, the extender and
// the next pipeline register.
interface ext_pipe_if
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  localparam int unsigned OFF_W = off_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  ext_op_e           in_op;
  logic [OFF_W-1:0]  in_off;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_op, in_off, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_op, in_off, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/ext_core.sv
// Combinational extender: immediate sign/zero/upper placement and
// byte/halfword load-lane extraction with misaligned-halfword detection.
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  localparam int unsigned OFF_W = off_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  ext_op_e           op,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;
  localparam int unsigned PAD_W = DATA_W + 8;
  localparam int unsigned IDX_W = $clog2(PAD_W);

  logic [PAD_W-1:0] padded;
  logic [IDX_W-1:0] base;
  logic [IMM_W-1:0] imm;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  // Zero byte on top keeps the halfword select in range at the last lane.
  assign padded = {8'h00, data};
  assign base   = IDX_W'({off, 3'b000});
  assign imm    = data[IMM_W-1:0];
  assign byte_v = padded[base +: 8];
  assign half_v = padded[base +: 16];

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      EXT_SEXT: result = {{EXT_W{imm[IMM_W-1]}}, imm};
      EXT_ZEXT: result = {{EXT_W{1'b0}}, imm};
      EXT_LUI:  result = {imm, {EXT_W{1'b0}}};
      EXT_LB:   result = {{(DATA_W-8){byte_v[7]}}, byte_v};
      EXT_LBU:  result = {{(DATA_W-8){1'b0}}, byte_v};
      EXT_LH: begin
        if (off[0]) err = 1'b1;
        else        result = {{(DATA_W-16){half_v[15]}}, half_v};
      end
      EXT_LHU: begin
        if (off[0]) err = 1'b1;
        else        result = {{(DATA_W-16){1'b0}}, half_v};
      end
      EXT_PASS: result = data;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered operand extender with valid/ready handshake and a two-entry skid
// buffer so one cycle of downstream stall is absorbed without loss.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned TAG_W  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  ext_pipe_if.slave  bus
);

  logic [DATA_W-1:0] core_data;
  logic              core_err;

  ext_state_e        state;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [TAG_W-1:0]  main_tag_q;
  logic              main_err_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [TAG_W-1:0]  skid_tag_q;
  logic              skid_err_q;

  logic              in_xfer_c;
  logic              out_xfer_c;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .data   (bus.in_data),
    .op     (bus.in_op),
    .off    (bus.in_off),
    .result (core_data),
    .err    (core_err)
  );

  assign in_xfer_c  = bus.in_valid && in_ready_q;
  assign out_xfer_c = out_valid_q && bus.out_ready;

  // Occupancy FSM; main register feeds the outputs, skid catches the beat
  // that arrives while the head is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_tag_q  <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer_c) begin
            main_data_q <= core_data;
            main_tag_q  <= bus.in_tag;
            main_err_q  <= core_err;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer_c && out_xfer_c) begin
            main_data_q <= core_data;
            main_tag_q  <= bus.in_tag;
            main_err_q  <= core_err;
          end else if (in_xfer_c) begin
            skid_data_q <= core_data;
            skid_tag_q  <= bus.in_tag;
            skid_err_q  <= core_err;
            in_ready_q  <= 1'b0;
            state       <= ST_TWO;
          end else if (out_xfer_c) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer_c) begin
            main_data_q <= skid_data_q;
            main_tag_q  <= skid_tag_q;
            main_err_q  <= skid_err_q;
            in_ready_q  <= 1'b1;
            state       <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_err   = main_err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed vectors plus randomized traffic with
// back-pressure, flush and reset, checked against an arithmetic reference model.
module tb_ext_pipe;
  import ext_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic hold_v = 1'b0;
  exp_t held;

  always #5 clk = ~clk;

  ext_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  ext_pipe #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Reference: plain integer arithmetic on the operation rules.
  function automatic exp_t model(int unsigned op, longint unsigned d, int unsigned off,
                                 logic [TAG_W-1:0] tag);
    longint unsigned mask;
    longint unsigned imm;
    longint unsigned b;
    longint unsigned h;
    longint unsigned r;
    exp_t e;
    mask  = (64'd1 << DATA_W) - 64'd1;
    imm   = d % (64'd1 << IMM_W);
    b     = (d >> (8 * off)) % 256;
    h     = (d >> (8 * off)) % 65536;
    r     = 0;
    e.err = 1'b0;
    case (op)
      0: r = (imm >= (64'd1 << (IMM_W - 1))) ? imm - (64'd1 << IMM_W) : imm;
      1: r = imm;
      2: r = imm << (DATA_W - IMM_W);
      3: r = (b >= 128) ? b - 256 : b;
      4: r = b;
      5, 6: begin
        if (off % 2 == 1) begin
          r     = 0;
          e.err = 1'b1;
        end else begin
          r = (op == 5 && h >= 32768) ? h - 65536 : h;
        end
      end
      default: r = d;
    endcase
    e.data = DATA_W'(r & mask);
    e.tag  = tag;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every output transfer, pushes on every input transfer.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        check("stall_stable", 64'({bus.out_valid, bus.out_data, bus.out_tag, bus.out_err}),
              64'({1'b1, held}));
      hold_v = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_spurious actual=%0h expected no beat", bus.out_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checks--;
            check("sb_beat", 64'({bus.out_data, bus.out_tag, bus.out_err}), 64'(e));
          end
        end else begin
          held   = {bus.out_data, bus.out_tag, bus.out_err};
          hold_v = 1'b1;
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(int'(bus.in_op), 64'(bus.in_data), int'(bus.in_off), bus.in_tag));
    end
  end

  task automatic set_in(int unsigned op, logic [DATA_W-1:0] d, int unsigned off,
                        logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = ext_op_e'(3'(op));
    bus.in_data  = d;
    bus.in_off   = OFF_W'(off);
    bus.in_tag   = tag;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(int unsigned op, logic [DATA_W-1:0] d, int unsigned off,
                      logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    set_in(op, d, off, tag);
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic one_shot(string name, int unsigned op, logic [DATA_W-1:0] d,
                          int unsigned off, logic [TAG_W-1:0] tag,
                          logic [DATA_W-1:0] exp_d, logic exp_err);
    send(op, d, off, tag);
    idle();
    @(negedge clk);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_data"},  64'(bus.out_data),  64'(exp_d));
    check({name, "_tag"},   64'(bus.out_tag),   64'(tag));
    check({name, "_err"},   64'(bus.out_err),   64'(exp_err));
    @(posedge clk);
    #2;
  endtask

  task automatic rand_cycle(int unsigned flush_pct);
    if ($urandom_range(0, 99) < 60)
      set_in($urandom_range(0, 7), DATA_W'($urandom), $urandom_range(0, DATA_W / 8 - 1),
             TAG_W'($urandom));
    else
      idle();
    bus.out_ready = ($urandom_range(0, 99) < 65);
    flush         = ($urandom_range(0, 99) < flush_pct);
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero_state(string name);
    @(negedge clk);
    check({name, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_out_data"},  64'(bus.out_data),  64'd0);
    check({name, "_out_tag"},   64'(bus.out_tag),   64'd0);
    check({name, "_out_err"},   64'(bus.out_err),   64'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    set_in(7, '1, 0, '1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    idle();
    check_zero_state("rst");

    one_shot("zext",  1, 32'h0000_8001, 0, 5'd7,  32'h0000_8001, 1'b0);
    one_shot("sext",  0, 32'h0000_8001, 0, 5'd8,  32'hFFFF_8001, 1'b0);
    one_shot("lui",   2, 32'h0000_8001, 3, 5'd9,  32'h8001_0000, 1'b0);
    one_shot("lb3",   3, 32'h80FF_7F01, 3, 5'd10, 32'hFFFF_FF80, 1'b0);
    one_shot("lbu1",  4, 32'h80FF_7F01, 1, 5'd11, 32'h0000_007F, 1'b0);
    one_shot("lh2",   5, 32'h80FF_7F01, 2, 5'd12, 32'hFFFF_80FF, 1'b0);
    one_shot("lhu1",  6, 32'h80FF_7F01, 1, 5'd13, 32'h0000_0000, 1'b1);
    one_shot("lhu2",  6, 32'h80FF_7F01, 2, 5'd14, 32'h0000_80FF, 1'b0);
    one_shot("pass",  7, 32'h80FF_7F01, 3, 5'd15, 32'h80FF_7F01, 1'b0);

    // Back-pressure: A and B fill both entries, C must wait.
    bus.out_ready = 1'b0;
    send(7, 32'hAAAA_0001, 0, 5'd1);
    send(7, 32'hBBBB_0002, 0, 5'd2);
    set_in(7, 32'hCCCC_0003, 0, 5'd3);
    @(negedge clk);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_head",     64'(bus.out_data), 64'h0000_0000_AAAA_0001);
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    send(7, 32'hCCCC_0003, 0, 5'd3);
    idle();
    repeat (4) @(posedge clk);
    #2;
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Flush while full, with a beat offered and downstream ready.
    bus.out_ready = 1'b0;
    send(7, 32'h1111_1111, 0, 5'd4);
    send(7, 32'h2222_2222, 0, 5'd5);
    set_in(7, 32'h3333_3333, 0, 5'd6);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush2_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush2_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (4) @(posedge clk);
    #2;

    // Flush from empty with an acceptable beat offered: the beat is dropped.
    set_in(7, 32'h4444_4444, 0, 5'd7);
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush0_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #2;

    // Reset mid-stream with toggling out_ready, then a 1-cycle-latency beat.
    one_shot("pre_rst", 7, 32'h5A5A_A5A5, 0, 5'd21, 32'h5A5A_A5A5, 1'b0);
    bus.out_ready = 1'b0;
    send(7, 32'h6666_0001, 0, 5'd22);
    for (int i = 0; i < 12; i++) rand_cycle(0);
    flush         = 1'b0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    set_in(7, 32'h7777_7777, 0, 5'd23);
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle();
    check_zero_state("mid_rst");
    one_shot("post_rst", 1, 32'hFFFF_1234, 0, 5'd24, 32'h0000_1234, 1'b0);

    for (int i = 0; i < 400; i++) rand_cycle(2);
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    repeat (5) @(posedge clk);
    #2;
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
